// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the writeback path and the register file.
package cpu_pkg;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int WORD_W   = 32;

    // Requester positions inside the two-bit request/grant vectors.
    localparam int REQ_EX  = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        GRANT_EX  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester not granted most recently wins a tie.
module cpu_rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       fire,
    output logic [1:0] gnt
);

    grant_t last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt[REQ_EX]  = 1'b1;
            2'b10:   gnt[REQ_MEM] = 1'b1;
            2'b11: begin
                if (last_grant == GRANT_MEM) begin
                    gnt[REQ_EX] = 1'b1;
                end else begin
                    gnt[REQ_MEM] = 1'b1;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Reset to MEM so that EX wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= GRANT_MEM;
        end else if (fire) begin
            last_grant <= gnt[REQ_EX] ? GRANT_EX : GRANT_MEM;
        end
    end

endmodule

// File: rtl/cpu_writeback_arbiter.sv
// Shares the register-file write port between execute and memory results and
// tracks pending writes per register so decode can stall on RAW hazards.
module cpu_writeback_arbiter
    import cpu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex_valid_i,
    input  logic [IDX_W-1:0]    ex_index_i,
    input  logic [WORD_W-1:0]   ex_value_i,
    output logic                ex_ready_o,
    input  logic                mem_valid_i,
    input  logic [IDX_W-1:0]    mem_index_i,
    input  logic [WORD_W-1:0]   mem_value_i,
    output logic                mem_ready_o,
    input  logic                reserve_i,
    input  logic [IDX_W-1:0]    reserve_index_i,
    input  logic [IDX_W-1:0]    read_index1_i,
    input  logic [IDX_W-1:0]    read_index2_i,
    output logic                busy1_o,
    output logic                busy2_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                write_enable_o,
    output logic [IDX_W-1:0]    reg_write_index_o,
    output logic [WORD_W-1:0]   value_o
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                fire;
    logic [IDX_W-1:0]    win_index;
    logic [WORD_W-1:0]   win_value;
    logic [NUM_REGS-1:0] busy_next;

    assign req = {mem_valid_i, ex_valid_i};

    cpu_rr_arbiter2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req),
        .fire  (fire),
        .gnt   (gnt)
    );

    // Readies are forced low during reset so nothing is accepted and then dropped.
    assign ex_ready_o  = gnt[REQ_EX]  & ~rst_i;
    assign mem_ready_o = gnt[REQ_MEM] & ~rst_i;
    assign fire        = ex_ready_o | mem_ready_o;

    assign win_index = ex_ready_o ? ex_index_i : mem_index_i;
    assign win_value = ex_ready_o ? ex_value_i : mem_value_i;

    // Stage boundary: accepted result -> registered register-file write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_enable_o    <= 1'b0;
            reg_write_index_o <= '0;
            value_o           <= '0;
        end else begin
            write_enable_o <= fire;
            if (fire) begin
                reg_write_index_o <= win_index;
                value_o           <= win_value;
            end
        end
    end

    // Clear applied before set so a same-cycle reserve keeps the bit pending.
    always_comb begin
        busy_next = busy_o;
        if (write_enable_o) begin
            busy_next = busy_next & ~reg_onehot(reg_write_index_o);
        end
        if (reserve_i) begin
            busy_next = busy_next | reg_onehot(reserve_index_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_next;
        end
    end

    assign busy1_o = busy_o[read_index1_i];
    assign busy2_o = busy_o[read_index2_i];

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Directed bench for cpu_writeback_arbiter with a write scoreboard and monitor.
module tb_cpu_writeback_arbiter;
    import cpu_pkg::*;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                ex_valid_i;
    logic [IDX_W-1:0]    ex_index_i;
    logic [WORD_W-1:0]   ex_value_i;
    logic                ex_ready_o;
    logic                mem_valid_i;
    logic [IDX_W-1:0]    mem_index_i;
    logic [WORD_W-1:0]   mem_value_i;
    logic                mem_ready_o;
    logic                reserve_i;
    logic [IDX_W-1:0]    reserve_index_i;
    logic [IDX_W-1:0]    read_index1_i;
    logic [IDX_W-1:0]    read_index2_i;
    logic                busy1_o;
    logic                busy2_o;
    logic [NUM_REGS-1:0] busy_o;
    logic                write_enable_o;
    logic [IDX_W-1:0]    reg_write_index_o;
    logic [WORD_W-1:0]   value_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] val;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    cpu_writeback_arbiter dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .ex_valid_i        (ex_valid_i),
        .ex_index_i        (ex_index_i),
        .ex_value_i        (ex_value_i),
        .ex_ready_o        (ex_ready_o),
        .mem_valid_i       (mem_valid_i),
        .mem_index_i       (mem_index_i),
        .mem_value_i       (mem_value_i),
        .mem_ready_o       (mem_ready_o),
        .reserve_i         (reserve_i),
        .reserve_index_i   (reserve_index_i),
        .read_index1_i     (read_index1_i),
        .read_index2_i     (read_index2_i),
        .busy1_o           (busy1_o),
        .busy2_o           (busy2_o),
        .busy_o            (busy_o),
        .write_enable_o    (write_enable_o),
        .reg_write_index_o (reg_write_index_o),
        .value_o           (value_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [WORD_W-1:0] val);
        wr_t e;
        e.idx = idx;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Monitor: every register-file write must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (write_enable_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_index=%0d actual_value=0x%0h required=no_write",
                         reg_write_index_o, value_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_index", 64'(reg_write_index_o), 64'(e.idx));
                check("wr_value", 64'(value_o), 64'(e.val));
            end
        end
    end

    // Decode must never reserve a pending register unless it is being retired this edge.
    always @(negedge clk) begin
        #3;
        if (rst_i === 1'b0 && reserve_i === 1'b1) begin
            checks++;
            if (busy_o[reserve_index_i] &&
                !(write_enable_o && reg_write_index_o == reserve_index_i)) begin
                failures++;
                $display("FAIL waw_reserve actual=reserve_of_busy_r%0d required=not_busy",
                         reserve_index_i);
            end
        end
    end

    initial begin
        rst_i           = 1'b1;
        ex_valid_i      = 1'b1;
        ex_index_i      = '0;
        ex_value_i      = '0;
        mem_valid_i     = 1'b1;
        mem_index_i     = '0;
        mem_value_i     = '0;
        reserve_i       = 1'b0;
        reserve_index_i = '0;
        read_index1_i   = '0;
        read_index2_i   = '0;

        // Reset state, with both requesters valid to show readies stay low.
        repeat (2) @(negedge clk);
        check("rst_ex_ready", 64'(ex_ready_o), 64'd0);
        check("rst_mem_ready", 64'(mem_ready_o), 64'd0);
        check("rst_we", 64'(write_enable_o), 64'd0);
        check("rst_index", 64'(reg_write_index_o), 64'd0);
        check("rst_value", 64'(value_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        rst_i       = 1'b0;

        // Single ex write to a reserved r3.
        reserve_i       = 1'b1;
        reserve_index_i = 4'd3;
        @(negedge clk);
        check("t1_busy_set", 64'(busy_o), 64'h0008);
        reserve_i  = 1'b0;
        ex_valid_i = 1'b1;
        ex_index_i = 4'd3;
        ex_value_i = 32'h1234_5678;
        #1;
        check("t1_ex_ready", 64'(ex_ready_o), 64'd1);
        check("t1_mem_ready", 64'(mem_ready_o), 64'd0);
        push_exp(4'd3, 32'h1234_5678);
        @(negedge clk);
        ex_valid_i = 1'b0;
        check("t1_we", 64'(write_enable_o), 64'd1);
        check("t1_busy_during_write", 64'(busy_o[3]), 64'd1);
        @(negedge clk);
        check("t1_busy_cleared", 64'(busy_o[3]), 64'd0);
        check("t1_we_idle", 64'(write_enable_o), 64'd0);
        check("t1_value_held", 64'(value_o), 64'h1234_5678);

        // Continuous contention after reset alternates ex, mem, ex, mem.
        do_reset();
        ex_valid_i  = 1'b1;
        ex_index_i  = 4'd1;
        ex_value_i  = 32'hA;
        mem_valid_i = 1'b1;
        mem_index_i = 4'd2;
        mem_value_i = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_ex_ready", 64'(ex_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_mem_ready", 64'(mem_ready_o), (i % 2 == 1) ? 64'd1 : 64'd0);
            if (i % 2 == 0) push_exp(4'd1, 32'hA);
            else            push_exp(4'd2, 32'hB);
            @(negedge clk);
        end
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        @(negedge clk);

        // Reserve r5 on the edge that commits r5: reserve wins; a second commit clears.
        reserve_i       = 1'b1;
        reserve_index_i = 4'd5;
        @(negedge clk);
        reserve_i  = 1'b0;
        ex_valid_i = 1'b1;
        ex_index_i = 4'd5;
        ex_value_i = 32'h55;
        #1;
        check("t3_ex_ready", 64'(ex_ready_o), 64'd1);
        push_exp(4'd5, 32'h55);
        @(negedge clk);
        ex_valid_i      = 1'b0;
        reserve_i       = 1'b1;
        reserve_index_i = 4'd5;
        @(negedge clk);
        reserve_i = 1'b0;
        check("t3_reserve_wins", 64'(busy_o[5]), 64'd1);
        ex_valid_i = 1'b1;
        ex_value_i = 32'h56;
        push_exp(4'd5, 32'h56);
        @(negedge clk);
        ex_valid_i = 1'b0;
        @(negedge clk);
        check("t3_second_clear", 64'(busy_o[5]), 64'd0);

        // Source-operand busy lookups, retired through the mem port.
        reserve_i       = 1'b1;
        reserve_index_i = 4'd7;
        @(negedge clk);
        reserve_index_i = 4'd9;
        @(negedge clk);
        reserve_i     = 1'b0;
        read_index1_i = 4'd7;
        read_index2_i = 4'd9;
        #1;
        check("t4_busy1_set", 64'(busy1_o), 64'd1);
        check("t4_busy2_set", 64'(busy2_o), 64'd1);
        mem_valid_i = 1'b1;
        mem_index_i = 4'd7;
        mem_value_i = 32'h77;
        #1;
        check("t4_mem_ready", 64'(mem_ready_o), 64'd1);
        push_exp(4'd7, 32'h77);
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("t4_busy1_before_commit", 64'(busy1_o), 64'd1);
        @(negedge clk);
        check("t4_busy1_after_commit", 64'(busy1_o), 64'd0);
        check("t4_busy2_still", 64'(busy2_o), 64'd1);
        read_index1_i = 4'd9;
        read_index2_i = 4'd7;
        #1;
        check("t4_busy1_r9", 64'(busy1_o), 64'd1);
        check("t4_busy2_r7", 64'(busy2_o), 64'd0);

        // Asynchronous reset while a write is on the port and every register is busy.
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            reserve_i       = 1'b1;
            reserve_index_i = IDX_W'(i);
            @(negedge clk);
        end
        reserve_i  = 1'b0;
        ex_valid_i = 1'b1;
        ex_index_i = 4'd0;
        ex_value_i = 32'hDEAD_BEEF;
        #1;
        check("t5_ex_ready", 64'(ex_ready_o), 64'd1);
        push_exp(4'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        ex_valid_i = 1'b0;
        check("t5_busy_full", 64'(busy_o), 64'hFFFF);
        check("t5_we_before_reset", 64'(write_enable_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_we_async_clear", 64'(write_enable_o), 64'd0);
        check("t5_busy_async_clear", 64'(busy_o), 64'd0);
        ex_valid_i  = 1'b1;
        ex_index_i  = 4'd4;
        ex_value_i  = 32'h44;
        mem_valid_i = 1'b1;
        mem_index_i = 4'd6;
        mem_value_i = 32'h66;
        #1;
        check("t5_ready_in_reset", 64'({ex_ready_o, mem_ready_o}), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("t5_tie_ex_ready", 64'(ex_ready_o), 64'd1);
        check("t5_tie_mem_ready", 64'(mem_ready_o), 64'd0);
        push_exp(4'd4, 32'h44);
        @(negedge clk);
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        @(negedge clk);

        // Three back-to-back mem writes with ex idle.
        mem_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_index_i = IDX_W'(10 + i);
            mem_value_i = 32'hA0 + 32'(i);
            #1;
            check("t6_mem_ready", 64'(mem_ready_o), 64'd1);
            push_exp(IDX_W'(10 + i), 32'hA0 + 32'(i));
            @(negedge clk);
            check("t6_back_to_back_we", 64'(write_enable_o), 64'd1);
        end
        mem_valid_i = 1'b0;
        @(negedge clk);
        check("t6_we_idle", 64'(write_enable_o), 64'd0);

        repeat (2) @(negedge clk);
        check("drain_expected_writes", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
